// File: rtl/sync_adder_pkg.sv
// Shared definitions for the pipelined segmented adder.
// Holds the operation encoding, the segment width helper and the
// saturation pattern generators used when SYNC_ADDER_SAT_EN is defined.
package sync_adder_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Widest datapath the saturation generators can describe.
  localparam int SAT_MAX_W = 256;

  // Width of one carry-ripple segment.
  // Returns 0 for an illegal WIDTH/STAGES pairing so the datapath fails to elaborate.
  function automatic int seg_width(input int width, input int stages);
    if (stages < 1 || stages > width || (width % stages) != 0) begin
      return 0;
    end
    return width / stages;
  endfunction

  // Largest positive two's-complement value of the given width: 0111..1.
  function automatic logic [SAT_MAX_W-1:0] signed_max(input int width);
    return (SAT_MAX_W'(1) << (width - 1)) - SAT_MAX_W'(1);
  endfunction

  // Most negative two's-complement value of the given width: 1000..0.
  function automatic logic [SAT_MAX_W-1:0] signed_min(input int width);
    return SAT_MAX_W'(1) << (width - 1);
  endfunction

endpackage

// File: rtl/sync_adder_seg.sv
// One pipeline stage of the segmented adder.
// Adds one SEG-bit slice plus the incoming carry and registers the sum slice,
// the carry out and the stage valid bit whenever the stage is allowed to advance.
module sync_adder_seg #(
  parameter int SEG = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           adv,
  input  logic           valid_in,
  input  logic [SEG-1:0] a,
  input  logic [SEG-1:0] b,
  input  logic           carry_in,
  output logic           valid_out,
  output logic [SEG-1:0] sum_out,
  output logic           carry_out
);

  logic [SEG:0] total;

  assign total = {1'b0, a} + {1'b0, b} + (SEG + 1)'(carry_in);

  // Capture the segment result; a stalled stage keeps both data and valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_out <= 1'b0;
      sum_out   <= '0;
      carry_out <= 1'b0;
    end else if (adv) begin
      valid_out <= valid_in;
      sum_out   <= total[SEG-1:0];
      carry_out <= total[SEG];
    end
  end

endmodule

// File: rtl/sync_adder_pipe.sv
// Pipelined WIDTH-bit add/subtract split into STAGES carry-ripple segments
// with valid/ready flow control, signed overflow and carry-out reporting.
// Optional feature macro: SYNC_ADDER_SAT_EN adds the 'sat' port, which clamps
// an overflowing result to signed max/min in the last stage.
module sync_adder_pipe
  import sync_adder_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sub,
  input  logic             cin,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
`ifdef SYNC_ADDER_SAT_EN
  input  logic             sat,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  logic [WIDTH-1:0]  y_eff;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] v;
  logic [STAGES-1:0] valid_in;
  logic [STAGES-1:0] carry_in;
  logic [STAGES-1:0] carry_r;
  logic [STAGES-1:0] x_msb_in;
  logic [STAGES-1:0] y_msb_in;
  logic [STAGES-1:0] x_msb_r;
  logic [STAGES-1:0] y_msb_r;
`ifdef SYNC_ADDER_SAT_EN
  logic [STAGES-1:0] sat_in;
  logic [STAGES-1:0] sat_r;
`endif

  // src_*: operand bits seen by stage k, with its own segment in the low SEG bits.
  // pend_*: what stage k hands on, already shifted down by one segment.
  // done_r: finished sum bits, kept left-aligned so each new segment enters at the top.
  logic [WIDTH-1:0] src_x  [STAGES];
  logic [WIDTH-1:0] src_y  [STAGES];
  logic [WIDTH-1:0] pend_x [STAGES];
  logic [WIDTH-1:0] pend_y [STAGES];
  logic [WIDTH-1:0] done_in[STAGES];
  logic [WIDTH-1:0] done_r [STAGES];
  logic [WIDTH-1:0] acc    [STAGES];
  logic [SEG-1:0]   sum_seg[STAGES];

  logic [WIDTH-1:0] sum_raw;

  assign y_eff = (sub == OP_SUB) ? ~y : y;

  // Backpressure chain: a stage may load when it is empty or the next one moves.
  always_comb begin
    adv = '0;
    adv[STAGES-1] = !v[STAGES-1] || out_ready;
    for (int k = STAGES - 2; k >= 0; k--) begin
      adv[k] = !v[k] || adv[k+1];
    end
  end

  // Route each stage's inputs: stage 0 from the ports, later stages from the previous registers.
  always_comb begin
    valid_in   = '0;
    carry_in   = '0;
    x_msb_in   = '0;
    y_msb_in   = '0;
    src_x[0]   = x;
    src_y[0]   = y_eff;
    done_in[0] = '0;
    valid_in[0] = in_valid;
    carry_in[0] = cin;
    x_msb_in[0] = x[WIDTH-1];
    y_msb_in[0] = y_eff[WIDTH-1];
    for (int k = 1; k < STAGES; k++) begin
      src_x[k]    = pend_x[k-1];
      src_y[k]    = pend_y[k-1];
      done_in[k]  = acc[k-1] >> SEG;
      valid_in[k] = v[k-1];
      carry_in[k] = carry_r[k-1];
      x_msb_in[k] = x_msb_r[k-1];
      y_msb_in[k] = y_msb_r[k-1];
    end
  end

`ifdef SYNC_ADDER_SAT_EN
  // The saturate request travels alongside its operands.
  always_comb begin
    sat_in    = '0;
    sat_in[0] = sat;
    for (int k = 1; k < STAGES; k++) begin
      sat_in[k] = sat_r[k-1];
    end
  end
`endif

  // Merge each stage's fresh segment on top of the lower bits already finished.
  always_comb begin
    for (int k = 0; k < STAGES; k++) begin
      acc[k] = (WIDTH'(sum_seg[k]) << (WIDTH - SEG)) | done_r[k];
    end
  end

  // Pass-through registers; they advance in lock-step with the segment registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        pend_x[k] <= '0;
        pend_y[k] <= '0;
        done_r[k] <= '0;
      end
      x_msb_r <= '0;
      y_msb_r <= '0;
`ifdef SYNC_ADDER_SAT_EN
      sat_r   <= '0;
`endif
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (adv[k]) begin
          pend_x[k]  <= src_x[k] >> SEG;
          pend_y[k]  <= src_y[k] >> SEG;
          done_r[k]  <= done_in[k];
          x_msb_r[k] <= x_msb_in[k];
          y_msb_r[k] <= y_msb_in[k];
`ifdef SYNC_ADDER_SAT_EN
          sat_r[k]   <= sat_in[k];
`endif
        end
      end
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    sync_adder_seg #(
      .SEG(SEG)
    ) u_seg (
      .clk      (clk),
      .rst      (rst),
      .adv      (adv[k]),
      .valid_in (valid_in[k]),
      .a        (src_x[k][SEG-1:0]),
      .b        (src_y[k][SEG-1:0]),
      .carry_in (carry_in[k]),
      .valid_out(v[k]),
      .sum_out  (sum_seg[k]),
      .carry_out(carry_r[k])
    );
  end

  assign in_ready  = adv[0];
  assign out_valid = v[STAGES-1];
  assign cout      = carry_r[STAGES-1];
  assign sum_raw   = acc[STAGES-1];
  assign ovf       = (x_msb_r[STAGES-1] == y_msb_r[STAGES-1]) &&
                     (sum_raw[WIDTH-1] != x_msb_r[STAGES-1]);

`ifdef SYNC_ADDER_SAT_EN
  // Clamp an overflowing result toward the sign of x; ovf itself is still reported.
  always_comb begin
    s = sum_raw;
    if (sat_r[STAGES-1] && ovf) begin
      s = x_msb_r[STAGES-1] ? WIDTH'(signed_min(WIDTH)) : WIDTH'(signed_max(WIDTH));
    end
  end
`else
  assign s = sum_raw;
`endif

endmodule

// File: tb/tb_sync_adder_pipe.sv
// Self-checking bench for sync_adder_pipe.
// Exercises three configurations (8/2, 4/1, 32/4); sat checks compile in
// only when SYNC_ADDER_SAT_EN is defined.
`timescale 1ns/1ps
module tb_sync_adder_pipe;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // WIDTH=8, STAGES=2
  logic       in_valid8, in_ready8, sub8, cin8, out_valid8, out_ready8, cout8, ovf8;
  logic [7:0] x8, y8, s8;
  // WIDTH=4, STAGES=1
  logic       in_valid4, in_ready4, sub4, cin4, out_valid4, out_ready4, cout4, ovf4;
  logic [3:0] x4, y4, s4;
  // WIDTH=32, STAGES=4
  logic        in_valid32, in_ready32, sub32, cin32, out_valid32, out_ready32, cout32, ovf32;
  logic [31:0] x32, y32, s32;
`ifdef SYNC_ADDER_SAT_EN
  logic sat8, sat4, sat32;
`endif

  sync_adder_pipe #(.WIDTH(8), .STAGES(2)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
    .sub(sub8), .cin(cin8), .x(x8), .y(y8),
`ifdef SYNC_ADDER_SAT_EN
    .sat(sat8),
`endif
    .out_valid(out_valid8), .out_ready(out_ready8), .s(s8), .cout(cout8), .ovf(ovf8)
  );

  sync_adder_pipe #(.WIDTH(4), .STAGES(1)) u_dut4 (
    .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4),
    .sub(sub4), .cin(cin4), .x(x4), .y(y4),
`ifdef SYNC_ADDER_SAT_EN
    .sat(sat4),
`endif
    .out_valid(out_valid4), .out_ready(out_ready4), .s(s4), .cout(cout4), .ovf(ovf4)
  );

  sync_adder_pipe #(.WIDTH(32), .STAGES(4)) u_dut32 (
    .clk(clk), .rst(rst), .in_valid(in_valid32), .in_ready(in_ready32),
    .sub(sub32), .cin(cin32), .x(x32), .y(y32),
`ifdef SYNC_ADDER_SAT_EN
    .sat(sat32),
`endif
    .out_valid(out_valid32), .out_ready(out_ready32), .s(s32), .cout(cout32), .ovf(ovf32)
  );

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid8, s8, cout8, ovf8} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut8: got valid=%b s=%h cout=%b ovf=%b, want all 0", out_valid8, s8, cout8, ovf8);
    end
    checks++;
    if ({out_valid4, s4, cout4, ovf4} !== 7'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut4: got valid=%b s=%h cout=%b ovf=%b, want all 0", out_valid4, s4, cout4, ovf4);
    end
    checks++;
    if ({out_valid32, s32, cout32, ovf32} !== 35'b0) begin
      errors++;
      $display("[TB] FAIL reset_dut32: got valid=%b s=%h cout=%b ovf=%b, want all 0", out_valid32, s32, cout32, ovf32);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({in_ready8, in_ready4, in_ready32} !== 3'b111) begin
      errors++;
      $display("[TB] FAIL reset_in_ready: got %b, want 111", {in_ready8, in_ready4, in_ready32});
    end
  endtask

  // 8'hFF + 8'h01: wraps to 0 with carry, no signed overflow; 2-cycle latency.
  task automatic test_add_carry();
    x8 = 8'hFF; y8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_carry_early: out_valid=%b after 1 cycle, want 0", out_valid8);
    end
    @(negedge clk);
    checks++;
    if ({out_valid8, cout8, ovf8, s8} !== {1'b1, 1'b1, 1'b0, 8'h00}) begin
      errors++;
      $display("[TB] FAIL add_carry: got valid=%b cout=%b ovf=%b s=%h, want 1 1 0 00", out_valid8, cout8, ovf8, s8);
    end
    @(negedge clk);
    checks++;
    if (out_valid8 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL add_carry_drain: out_valid=%b, want 0", out_valid8);
    end
  endtask

  // 8'h80 - 8'h01 with cin=1: 80+FE+1 = 17F, signed overflow.
  task automatic test_sub_overflow();
    logic [7:0] want_s;
    x8 = 8'h80; y8 = 8'h01; cin8 = 1'b1; sub8 = 1'b1; out_ready8 = 1'b1; in_valid8 = 1'b1;
    want_s = 8'h7F;
`ifdef SYNC_ADDER_SAT_EN
    sat8 = 1'b1;
    want_s = 8'h80;
`endif
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid8, cout8, ovf8, s8} !== {1'b1, 1'b1, 1'b1, want_s}) begin
      errors++;
      $display("[TB] FAIL sub_overflow: got valid=%b cout=%b ovf=%b s=%h, want 1 1 1 %h", out_valid8, cout8, ovf8, s8, want_s);
    end
`ifdef SYNC_ADDER_SAT_EN
    // Positive overflow clamps to signed max: 7F + 01 -> 7F.
    x8 = 8'h7F; y8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0; sat8 = 1'b1; in_valid8 = 1'b1;
    @(negedge clk);
    in_valid8 = 1'b0;
    @(negedge clk);
    checks++;
    if ({out_valid8, cout8, ovf8, s8} !== {1'b1, 1'b0, 1'b1, 8'h7F}) begin
      errors++;
      $display("[TB] FAIL sat_max: got valid=%b cout=%b ovf=%b s=%h, want 1 0 1 7f", out_valid8, cout8, ovf8, s8);
    end
    sat8 = 1'b0;
`endif
    @(negedge clk);
  endtask

  // Single-stage build: 7 + 1 = 8 with signed overflow after one cycle.
  task automatic test_single_stage();
    x4 = 4'h7; y4 = 4'h1; cin4 = 1'b0; sub4 = 1'b0; out_ready4 = 1'b1; in_valid4 = 1'b1;
    @(negedge clk);
    in_valid4 = 1'b0;
    checks++;
    if ({out_valid4, cout4, ovf4, s4} !== {1'b1, 1'b0, 1'b1, 4'h8}) begin
      errors++;
      $display("[TB] FAIL single_stage: got valid=%b cout=%b ovf=%b s=%h, want 1 0 1 8", out_valid4, cout4, ovf4, s4);
    end
    @(negedge clk);
    checks++;
    if (out_valid4 !== 1'b0) begin
      errors++;
      $display("[TB] FAIL single_stage_drain: out_valid=%b, want 0", out_valid4);
    end
  endtask

  // Six adds (i, i+1) with out_ready low for the first 4 cycles.
  task automatic test_backpressure();
    int sent = 0;
    int got = 0;
    int stall_accepts = 0;
    sub8 = 1'b0; cin8 = 1'b0;
    for (int cyc = 0; cyc < 40 && got < 6; cyc++) begin
      in_valid8  = (sent < 6);
      x8         = 8'(sent);
      y8         = 8'(sent + 1);
      out_ready8 = (cyc >= 4);
      #1;
      if (out_valid8 && !out_ready8) begin
        checks++;
        if ({cout8, ovf8, s8} !== {2'b00, 8'(2 * got + 1)}) begin
          errors++;
          $display("[TB] FAIL bp_held: cycle %0d got s=%h, want %h", cyc, s8, 8'(2 * got + 1));
        end
      end
      if (out_valid8 && out_ready8) begin
        checks++;
        if ({cout8, ovf8, s8} !== {2'b00, 8'(2 * got + 1)}) begin
          errors++;
          $display("[TB] FAIL bp_result: result %0d got s=%h cout=%b ovf=%b, want s=%h", got, s8, cout8, ovf8, 8'(2 * got + 1));
        end
        got++;
      end
      if (in_valid8 && in_ready8) begin
        sent++;
        if (!out_ready8) stall_accepts++;
      end
      @(negedge clk);
    end
    in_valid8 = 1'b0;
    checks++;
    if (got !== 6) begin
      errors++;
      $display("[TB] FAIL bp_count: got %0d results, want 6", got);
    end
    checks++;
    if (stall_accepts !== 2) begin
      errors++;
      $display("[TB] FAIL bp_stall_accepts: accepted %0d while stalled, want 2", stall_accepts);
    end
    out_ready8 = 1'b1;
    @(negedge clk);
  endtask

  // Reset with two operations in flight clears everything immediately.
  task automatic test_reset_midop();
    out_ready8 = 1'b1; sub8 = 1'b0; cin8 = 1'b0;
    x8 = 8'd10; y8 = 8'd20; in_valid8 = 1'b1;
    @(negedge clk);
    x8 = 8'd30; y8 = 8'd40;
    @(negedge clk);
    in_valid8 = 1'b0;
    checks++;
    if ({out_valid8, s8} !== {1'b1, 8'd30}) begin
      errors++;
      $display("[TB] FAIL midop_inflight: got valid=%b s=%h, want 1 1e", out_valid8, s8);
    end
    rst = 1'b1;
    #1;
    checks++;
    if ({out_valid8, s8, cout8, ovf8} !== 11'b0) begin
      errors++;
      $display("[TB] FAIL midop_reset: got valid=%b s=%h cout=%b ovf=%b, want all 0", out_valid8, s8, cout8, ovf8);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (out_valid8 !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midop_stale: cycle %0d out_valid=%b, want 0", i, out_valid8);
      end
    end
  endtask

  // 32/4 streaming: eight ops accepted back-to-back come out on consecutive cycles.
  task automatic test_back_to_back();
    logic want_v;
    out_ready32 = 1'b1; sub32 = 1'b0; cin32 = 1'b0;
    for (int cyc = 0; cyc < 14; cyc++) begin
      in_valid32 = (cyc < 8);
      x32 = 32'(cyc * 3);
      y32 = 32'(cyc);
      #1;
      if (cyc < 8) begin
        checks++;
        if (in_ready32 !== 1'b1) begin
          errors++;
          $display("[TB] FAIL b2b_ready: cycle %0d in_ready=%b, want 1", cyc, in_ready32);
        end
      end
      want_v = (cyc >= 4) && (cyc < 12);
      checks++;
      if (out_valid32 !== want_v) begin
        errors++;
        $display("[TB] FAIL b2b_valid: cycle %0d out_valid=%b, want %b", cyc, out_valid32, want_v);
      end else if (want_v) begin
        checks++;
        if ({cout32, ovf32, s32} !== {2'b00, 32'((cyc - 4) * 4)}) begin
          errors++;
          $display("[TB] FAIL b2b_result: cycle %0d s=%h, want %h", cyc, s32, 32'((cyc - 4) * 4));
        end
      end
      @(negedge clk);
    end
    in_valid32 = 1'b0;
  endtask

  // 32/4 with random operands, random in_valid and random out_ready against a queue model.
  task automatic test_random();
    int sent = 0;
    int got = 0;
    logic [33:0] expq[$];
    logic [33:0] want;
    logic [31:0] ye;
    logic [32:0] full;
    localparam int NOPS = 2000;
    for (int cyc = 0; cyc < 12000 && got < NOPS; cyc++) begin
      in_valid32  = (sent < NOPS) && ($urandom_range(0, 3) != 0);
      x32         = $urandom;
      y32         = $urandom;
      sub32       = 1'($urandom_range(0, 1));
      cin32       = 1'($urandom_range(0, 1));
      out_ready32 = ($urandom_range(0, 3) != 0);
      #1;
      if (out_valid32 && out_ready32) begin
        checks++;
        if (expq.size() == 0) begin
          errors++;
          $display("[TB] FAIL rand_extra: unexpected result s=%h", s32);
        end else begin
          want = expq.pop_front();
          if ({cout32, ovf32, s32} !== want) begin
            errors++;
            $display("[TB] FAIL rand_result: op %0d got cout=%b ovf=%b s=%h, want cout=%b ovf=%b s=%h",
                     got, cout32, ovf32, s32, want[33], want[32], want[31:0]);
          end
        end
        got++;
      end
      if (in_valid32 && in_ready32) begin
        ye   = sub32 ? ~y32 : y32;
        full = {1'b0, x32} + {1'b0, ye} + 33'(cin32);
        want = {full[32], (x32[31] == ye[31]) && (full[31] != x32[31]), full[31:0]};
        expq.push_back(want);
        sent++;
      end
      @(negedge clk);
    end
    in_valid32 = 1'b0;
    out_ready32 = 1'b1;
    checks++;
    if (got !== NOPS) begin
      errors++;
      $display("[TB] FAIL rand_count: got %0d results, want %0d", got, NOPS);
    end
  endtask

  initial begin
    rst = 1'b1;
    in_valid8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; x8 = '0; y8 = '0; out_ready8 = 1'b1;
    in_valid4 = 1'b0; sub4 = 1'b0; cin4 = 1'b0; x4 = '0; y4 = '0; out_ready4 = 1'b1;
    in_valid32 = 1'b0; sub32 = 1'b0; cin32 = 1'b0; x32 = '0; y32 = '0; out_ready32 = 1'b1;
`ifdef SYNC_ADDER_SAT_EN
    sat8 = 1'b0; sat4 = 1'b0; sat32 = 1'b0;
`endif
    test_reset();
    test_add_carry();
    test_sub_overflow();
    test_single_stage();
    test_backpressure();
    test_reset_midop();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
